// File: rtl/mem_port_arbiter.sv
// Fair two-port arbiter: serializes CPU fetch (A) and load/store (B) ports onto one word-memory port.
// Access is latched at grant; resp is a one-cycle pulse on the serviced port.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    read_a,
   input  logic                    write_a,
   input  logic [DATA_WIDTH/8-1:0] wmask_a,
   input  logic [ADDR_WIDTH-1:0]   address_a,
   input  logic [DATA_WIDTH-1:0]   wdata_a,
   output logic                    resp_a,
   output logic [DATA_WIDTH-1:0]   rdata_a,
   input  logic                    read_b,
   input  logic                    write_b,
   input  logic [DATA_WIDTH/8-1:0] wmask_b,
   input  logic [ADDR_WIDTH-1:0]   address_b,
   input  logic [DATA_WIDTH-1:0]   wdata_b,
   output logic                    resp_b,
   output logic [DATA_WIDTH-1:0]   rdata_b,
   output logic                    mem_read,
   output logic                    mem_write,
   output logic [DATA_WIDTH/8-1:0] mem_wmask,
   output logic [ADDR_WIDTH-1:0]   mem_address,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic                    mem_resp,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
);

   localparam int MW = DATA_WIDTH / 8;

   typedef enum logic [2:0] {IDLE, GRANT_A, GRANT_B, RESP_A, RESP_B} state_t;

   state_t                  state_q, state_d;
   logic                    last_b_q, last_b_d;
   logic                    op_wr_q, op_wr_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [MW-1:0]           wmask_q, wmask_d;
   logic [DATA_WIDTH-1:0]   rdata_a_q, rdata_a_d;
   logic [DATA_WIDTH-1:0]   rdata_b_q, rdata_b_d;

   logic req_a, req_b, pick_b, granted;

   assign req_a  = read_a | write_a;
   assign req_b  = read_b | write_b;
   // On a conflict the port that did not win last time goes first.
   assign pick_b = req_b & (~req_a | ~last_b_q);

   always_comb begin
      state_d   = state_q;
      last_b_d  = last_b_q;
      op_wr_d   = op_wr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wmask_d   = wmask_q;
      rdata_a_d = rdata_a_q;
      rdata_b_d = rdata_b_q;
      case (state_q)
         IDLE: begin
            if (req_a | req_b) begin
               state_d  = pick_b ? GRANT_B : GRANT_A;
               last_b_d = pick_b;
               op_wr_d  = pick_b ? write_b : write_a;
               addr_d   = pick_b ? address_b : address_a;
               wdata_d  = pick_b ? wdata_b : wdata_a;
               wmask_d  = pick_b ? wmask_b : wmask_a;
            end
         end
         GRANT_A: begin
            if (mem_resp) begin
               state_d = RESP_A;
               if (!op_wr_q) rdata_a_d = mem_rdata;
            end
         end
         GRANT_B: begin
            if (mem_resp) begin
               state_d = RESP_B;
               if (!op_wr_q) rdata_b_d = mem_rdata;
            end
         end
         RESP_A:  state_d = IDLE;
         RESP_B:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         last_b_q  <= 1'b0;
         op_wr_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wmask_q   <= '0;
         rdata_a_q <= '0;
         rdata_b_q <= '0;
      end else begin
         state_q   <= state_d;
         last_b_q  <= last_b_d;
         op_wr_q   <= op_wr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wmask_q   <= wmask_d;
         rdata_a_q <= rdata_a_d;
         rdata_b_q <= rdata_b_d;
      end
   end

   // Downstream signals decode only from state and the latched access.
   assign granted     = (state_q == GRANT_A) || (state_q == GRANT_B);
   assign mem_read    = granted & ~op_wr_q;
   assign mem_write   = granted & op_wr_q;
   assign mem_wmask   = mem_write ? wmask_q : '0;
   assign mem_address = granted ? addr_q : '0;
   assign mem_wdata   = mem_write ? wdata_q : '0;
   assign resp_a      = (state_q == RESP_A);
   assign resp_b      = (state_q == RESP_B);
   assign rdata_a     = rdata_a_q;
   assign rdata_b     = rdata_b_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Cycle-table bench for mem_port_arbiter plus hand sequences for reset-in-grant and zero-wait memory.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        read_a, write_a, read_b, write_b;
   logic [1:0]  wmask_a, wmask_b;
   logic [15:0] address_a, wdata_a, address_b, wdata_b;
   logic        resp_a, resp_b;
   logic [15:0] rdata_a, rdata_b;
   logic        mem_read, mem_write, mem_resp;
   logic [1:0]  mem_wmask;
   logic [15:0] mem_address, mem_wdata, mem_rdata;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
      .clk(clk), .rst(rst),
      .read_a(read_a), .write_a(write_a), .wmask_a(wmask_a), .address_a(address_a),
      .wdata_a(wdata_a), .resp_a(resp_a), .rdata_a(rdata_a),
      .read_b(read_b), .write_b(write_b), .wmask_b(wmask_b), .address_b(address_b),
      .wdata_b(wdata_b), .resp_b(resp_b), .rdata_b(rdata_b),
      .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
      .mem_address(mem_address), .mem_wdata(mem_wdata),
      .mem_resp(mem_resp), .mem_rdata(mem_rdata)
   );

   // One row = one clock cycle: inputs applied during the cycle, expected outputs at its start.
   typedef struct packed {
      logic        ra, wa;
      logic [1:0]  ma;
      logic [15:0] aa, da;
      logic        rb, wb;
      logic [1:0]  mb;
      logic [15:0] ab, db;
      logic        mr;
      logic [15:0] mrd;
      logic        e_rd, e_wr;
      logic [1:0]  e_wm;
      logic [15:0] e_addr, e_wd;
      logic        e_ra, e_rb;
      logic [15:0] e_rda, e_rdb;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic ra, wa, input logic [1:0] ma, input logic [15:0] aa, da,
                      input logic rb, wb, input logic [1:0] mb, input logic [15:0] ab, db,
                      input logic mr, input logic [15:0] mrd,
                      input logic e_rd, e_wr, input logic [1:0] e_wm, input logic [15:0] e_addr, e_wd,
                      input logic e_ra, e_rb, input logic [15:0] e_rda, e_rdb);
      vecs.push_back('{ra, wa, ma, aa, da, rb, wb, mb, ab, db, mr, mrd,
                       e_rd, e_wr, e_wm, e_addr, e_wd, e_ra, e_rb, e_rda, e_rdb});
   endtask

   task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      read_a = v.ra; write_a = v.wa; wmask_a = v.ma; address_a = v.aa; wdata_a = v.da;
      read_b = v.rb; write_b = v.wb; wmask_b = v.mb; address_b = v.ab; wdata_b = v.db;
      mem_resp = v.mr; mem_rdata = v.mrd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [69:0] act_word(input logic access);
      // Address/wdata/wmask only matter while a downstream request is active.
      return {mem_read, mem_write, access ? mem_wmask : 2'b00, access ? mem_address : 16'h0,
              access ? mem_wdata : 16'h0, resp_a, resp_b, rdata_a, rdata_b};
   endfunction

   initial begin
      vec_t z;
      z = '0;
      drive(z);
      rst = 1'b1;
      #1;
      chk("reset_outputs", act_word(1'b1), 70'h0);
      tick(); tick();
      rst = 1'b0;

      // Simultaneous reads right after reset: B first, then A.
      add(1,0,0,16'h0010,0, 1,0,0,16'h0020,0, 0,0,          0,0,0,0,0,            0,0,0,0);
      add(1,0,0,16'h0010,0, 1,0,0,16'h0020,0, 1,16'hB0B0,   1,0,0,16'h0020,0,     0,0,0,0);
      add(1,0,0,16'h0010,0, 1,0,0,16'h0020,0, 0,0,          0,0,0,0,0,            0,1,0,16'hB0B0);
      add(1,0,0,16'h0010,0, 0,0,0,0,0,        0,0,          0,0,0,0,0,            0,0,0,16'hB0B0);
      add(1,0,0,16'h0010,0, 0,0,0,0,0,        1,16'hA0A0,   1,0,0,16'h0010,0,     0,0,0,16'hB0B0);
      add(0,0,0,0,0,        0,0,0,0,0,        0,0,          0,0,0,0,0,            1,0,16'hA0A0,16'hB0B0);
      // Fairness: A held, B re-requests every time -> B, A, B, A.
      add(1,0,0,16'h0100,0, 1,0,0,16'h0200,0, 0,0,          0,0,0,0,0,            0,0,16'hA0A0,16'hB0B0);
      add(1,0,0,16'h0100,0, 1,0,0,16'h0200,0, 1,16'h1111,   1,0,0,16'h0200,0,     0,0,16'hA0A0,16'hB0B0);
      add(1,0,0,16'h0100,0, 1,0,0,16'h0200,0, 0,0,          0,0,0,0,0,            0,1,16'hA0A0,16'h1111);
      add(1,0,0,16'h0100,0, 1,0,0,16'h0200,0, 0,0,          0,0,0,0,0,            0,0,16'hA0A0,16'h1111);
      add(1,0,0,16'h0100,0, 1,0,0,16'h0200,0, 1,16'h2222,   1,0,0,16'h0100,0,     0,0,16'hA0A0,16'h1111);
      add(1,0,0,16'h0100,0, 1,0,0,16'h0200,0, 0,0,          0,0,0,0,0,            1,0,16'h2222,16'h1111);
      add(1,0,0,16'h0100,0, 1,0,0,16'h0200,0, 0,0,          0,0,0,0,0,            0,0,16'h2222,16'h1111);
      add(1,0,0,16'h0100,0, 1,0,0,16'h0200,0, 1,16'h3333,   1,0,0,16'h0200,0,     0,0,16'h2222,16'h1111);
      add(1,0,0,16'h0100,0, 1,0,0,16'h0200,0, 0,0,          0,0,0,0,0,            0,1,16'h2222,16'h3333);
      add(1,0,0,16'h0100,0, 1,0,0,16'h0200,0, 0,0,          0,0,0,0,0,            0,0,16'h2222,16'h3333);
      add(1,0,0,16'h0100,0, 1,0,0,16'h0200,0, 1,16'h4444,   1,0,0,16'h0100,0,     0,0,16'h2222,16'h3333);
      add(0,0,0,0,0,        0,0,0,0,0,        0,0,          0,0,0,0,0,            1,0,16'h4444,16'h3333);
      // A read alone, mem_resp three cycles after mem_read.
      add(1,0,0,16'h0040,0, 0,0,0,0,0,        0,0,          0,0,0,0,0,            0,0,16'h4444,16'h3333);
      add(1,0,0,16'h0040,0, 0,0,0,0,0,        0,0,          1,0,0,16'h0040,0,     0,0,16'h4444,16'h3333);
      add(1,0,0,16'h0040,0, 0,0,0,0,0,        0,0,          1,0,0,16'h0040,0,     0,0,16'h4444,16'h3333);
      add(1,0,0,16'h0040,0, 0,0,0,0,0,        0,0,          1,0,0,16'h0040,0,     0,0,16'h4444,16'h3333);
      add(1,0,0,16'h0040,0, 0,0,0,0,0,        1,16'h1234,   1,0,0,16'h0040,0,     0,0,16'h4444,16'h3333);
      add(1,0,0,16'h0040,0, 0,0,0,0,0,        0,0,          0,0,0,0,0,            1,0,16'h1234,16'h3333);
      // B byte write; stray mem_resp in IDLE and RESP is ignored; rdata_b untouched.
      add(0,0,0,0,0, 0,1,2'b10,16'h8002,16'hAB00, 1,0,      0,0,0,0,0,            0,0,16'h1234,16'h3333);
      add(0,0,0,0,0, 0,1,2'b10,16'h8002,16'hAB00, 0,0,      0,1,2'b10,16'h8002,16'hAB00, 0,0,16'h1234,16'h3333);
      add(0,0,0,0,0, 0,1,2'b10,16'h8002,16'hAB00, 1,16'hDEAD, 0,1,2'b10,16'h8002,16'hAB00, 0,0,16'h1234,16'h3333);
      add(0,0,0,0,0,        0,0,0,0,0,        1,0,          0,0,0,0,0,            0,1,16'h1234,16'h3333);
      add(0,0,0,0,0,        0,0,0,0,0,        0,0,          0,0,0,0,0,            0,0,16'h1234,16'h3333);
      // A read+write counts as write; request withdrawn during grant still completes.
      add(1,1,2'b11,16'h0055,16'h5A5A, 0,0,0,0,0, 0,0,      0,0,0,0,0,            0,0,16'h1234,16'h3333);
      add(0,0,0,16'hFFFF,0, 0,0,0,0,0,        0,0,          0,1,2'b11,16'h0055,16'h5A5A, 0,0,16'h1234,16'h3333);
      add(0,0,0,16'hFFFF,0, 0,0,0,0,0,        1,16'h7777,   0,1,2'b11,16'h0055,16'h5A5A, 0,0,16'h1234,16'h3333);
      add(0,0,0,0,0,        0,0,0,0,0,        0,0,          0,0,0,0,0,            1,0,16'h1234,16'h3333);
      add(0,0,0,0,0,        0,0,0,0,0,        0,0,          0,0,0,0,0,            0,0,16'h1234,16'h3333);

      for (int i = 0; i < vecs.size(); i++) begin
         vec_t v;
         logic acc;
         v = vecs[i];
         acc = v.e_rd | v.e_wr;
         drive(v);
         chk($sformatf("row%0d", i), act_word(acc),
             {v.e_rd, v.e_wr, v.e_wm, v.e_addr, v.e_wd, v.e_ra, v.e_rb, v.e_rda, v.e_rdb});
         if (resp_a && resp_b) chk($sformatf("row%0d_dual_resp", i), 70'd1, 70'd0);
         tick();
      end

      // Reset asserted mid-GRANT_B clears everything at once.
      drive(z);
      write_b = 1'b1; address_b = 16'h0300; wdata_b = 16'h0F0F; wmask_b = 2'b01;
      tick();
      chk("pre_reset_grant_b", {mem_write, mem_address, mem_wdata, mem_wmask},
          {1'b1, 16'h0300, 16'h0F0F, 2'b01});
      rst = 1'b1;
      #1;
      chk("reset_in_grant", {mem_read, mem_write, resp_a, resp_b, rdata_a, rdata_b}, 36'h0);
      drive(z);
      tick();
      rst = 1'b0;
      read_a = 1'b1; address_a = 16'h0A0A;
      read_b = 1'b1; address_b = 16'h0B0B;
      tick();
      chk("post_reset_b_first", {mem_read, mem_write, mem_address}, {1'b1, 1'b0, 16'h0B0B});
      read_a = 1'b0; read_b = 1'b0;
      mem_resp = 1'b1; mem_rdata = 16'h5555;
      tick();
      chk("post_reset_resp_b", {resp_a, resp_b, rdata_b}, {1'b0, 1'b1, 16'h5555});
      tick();

      // Zero-wait memory: mem_resp tied high, request held through the resp cycle.
      mem_rdata = 16'h6666;
      read_a = 1'b1; address_a = 16'h0777;
      chk("zw_idle", {mem_read, resp_a}, 2'b00);
      tick();
      chk("zw_cycle1", {mem_read, mem_address, resp_a}, {1'b1, 16'h0777, 1'b0});
      tick();
      chk("zw_cycle2_resp", {mem_read, resp_a, rdata_a}, {1'b0, 1'b1, 16'h6666});
      tick();
      chk("zw_cycle3_idle", {mem_read, mem_write, resp_a}, 3'b000);
      read_a = 1'b0;
      tick();
      chk("zw_no_double", {mem_read, mem_write, resp_a, resp_b}, 4'b0000);
      tick();
      chk("zw_quiet", {mem_read, resp_a, rdata_a}, {1'b0, 1'b0, 16'h6666});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Responder for the CPU pipeline's two split memory ports: Port A (instruction fetch) and Port B (data load/store).
- Serializes both ports onto one downstream word-memory interface (cache or physical memory) with a fair arbitration FSM.
- Returns a one-cycle resp pulse and read data to the requesting port.
- Sits between cpu_datapath and the memory hierarchy.

Parameters:
- ADDR_WIDTH, 16, address width on all ports.
- DATA_WIDTH, 16, data width on all ports; wmask width is DATA_WIDTH/8.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- read_a  input  1  Port A read request, held until resp_a.
- write_a  input  1  Port A write request, held until resp_a.
- wmask_a  input  2  Port A byte enables (bit1 = high byte).
- address_a  input  16  Port A word address.
- wdata_a  input  16  Port A write data.
- resp_a  output  1  Port A completion pulse.
- rdata_a  output  16  Port A read data, valid when resp_a=1.
- read_b, write_b, wmask_b, address_b, wdata_b, resp_b, rdata_b: same widths and meanings for Port B.
- mem_read  output  1  downstream read request.
- mem_write  output  1  downstream write request.
- mem_wmask  output  2  downstream byte enables.
- mem_address  output  16  downstream address.
- mem_wdata  output  16  downstream write data.
- mem_resp  input  1  downstream completion, one cycle.
- mem_rdata  input  16  downstream read data, valid with mem_resp.

Behaviour:
- Reset (async, rst=1): state=IDLE, last_grant=A, and every output is 0, including rdata_a and rdata_b. An in-flight downstream transaction is abandoned.
- States: IDLE, GRANT_A, GRANT_B, RESP_A, RESP_B.
- Request definitions: req_a = read_a|write_a; req_b = read_b|write_b. If read and write are both high on one port, the access is treated as a write.
- IDLE, arbitration:
  - Only A requests: go to GRANT_A.
  - Only B requests: go to GRANT_B.
  - Both request: grant the port that is not last_grant. After reset this means B is granted first.
- On the grant edge, latch the selected port's op, address, wdata and wmask into internal registers, and set last_grant.
- GRANT_x: outputs are driven from the latched registers, not the live ports.
  - mem_read or mem_write = 1, per the latched op.
  - mem_wmask = latched wmask on writes, 2'b00 on reads.
  - All downstream outputs stay stable until mem_resp.
  - Live port inputs are ignored; a request withdrawn mid-grant still completes and still gets resp.
- On mem_resp in GRANT_x:
  - Go to RESP_x.
  - On a read, capture mem_rdata into rdata_x.
  - On a write, rdata_x is unchanged.
- RESP_x: resp_x=1 for exactly this one cycle; mem_read=mem_write=0. Next state is always IDLE, so a request still held high during the resp cycle is never double-serviced.
- rdata_x holds its value until the next read completion on that port.
- Latency: request seen in IDLE at cycle 0 → mem request at cycle 1 → resp_x at cycle (mem_resp cycle + 1). With zero-wait memory (mem_resp in the first GRANT cycle), resp_x arrives at cycle 2.
- Throughput: at most one access per 3 cycles with zero-wait memory.
- mem_resp outside the GRANT states is ignored.
- resp_a and resp_b are never high in the same cycle.
- All outputs are registered or decoded from state and latched registers only; there is no combinational path from port inputs to outputs.

Test Plan:
- A read alone:
  - Stimulus: read_a=1, address_a=0x0040; memory returns 0x1234 with mem_resp 3 cycles after mem_read.
  - Required: mem_address=0x0040 and mem_wmask=0 while mem_read=1; one-cycle resp_a with rdata_a=0x1234; resp_b stays 0.
- B byte write:
  - Stimulus: write_b=1, address_b=0x8002, wdata_b=0xAB00, wmask_b=2'b10.
  - Required: mem_write=1 with those exact values; resp_b pulses once; rdata_b unchanged.
- Simultaneous requests after reset:
  - Stimulus: read_a (0x0010) and read_b (0x0020) rise together.
  - Required: B is serviced first (mem_address=0x0020), then A (0x0010); two separate resp pulses in that order.
- Fairness under back-to-back load:
  - Stimulus: B re-requests immediately after each resp_b while A is held pending.
  - Required: grants alternate B, A, B, A; A waits for at most one B transaction.
- Withdrawn request and reset:
  - Stimulus 1: drop read_a one cycle into GRANT_A.
  - Required 1: the transaction completes and resp_a still pulses.
  - Stimulus 2: assert rst while in GRANT_B.
  - Required 2: mem_write, resp_b, rdata_b and rdata_a go to 0 immediately; after release, a pending A+B conflict grants B first.
- Zero-wait memory:
  - Stimulus: mem_resp tied high.
  - Required: resp pulse 2 cycles after the request is seen in IDLE; no duplicate service of a request held through the resp cycle.
